// File: rtl/uart_sys_pkg.sv
// rtl/uart_sys_pkg.sv - shared opcodes, operand addresses and command FSM states
// Contents:
//   CMD_*         opcode byte values recognised by the command controller
//   OPA_ADDR/OPB_ADDR  register-file slots that hold the ALU operands
//   cmd_state_t   command controller state encoding
//   is_collect()  true for states that are waiting for a frame byte
package uart_sys_pkg;

    localparam logic [7:0] CMD_WR      = 8'hAA;
    localparam logic [7:0] CMD_RD      = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

    localparam int OPA_ADDR = 0;
    localparam int OPB_ADDR = 1;

    typedef enum logic [3:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        RD_ADDR,
        RD_WAIT,
        OPA,
        OPB,
        ALU_FUN,
        ALU_WAIT,
        SEND_RD,
        SEND_LO,
        SEND_HI
    } cmd_state_t;

    function automatic logic is_collect(cmd_state_t s);
        return s inside {WR_ADDR, WR_DATA, RD_ADDR, OPA, OPB, ALU_FUN};
    endfunction

endpackage

// File: rtl/frame_timeout_counter.sv
// rtl/frame_timeout_counter.sv - idle-cycle counter with terminal-count flag
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   clear     restart counting from zero
//   enable    count while high; held at zero while low
//   tc        high while the count sits at TIMEOUT_CYC-1 and counting is enabled
module frame_timeout_counter #(
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    logic [15:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear || !enable) begin
            count <= '0;
        end else begin
            count <= count + 16'd1;
        end
    end

    // Decoded from the count register only, so the owner may feed tc back
    // into clear without forming a combinational loop.
    assign tc = enable && (count == 16'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/uart_rx_cmd_ctrl.sv
// rtl/uart_rx_cmd_ctrl.sv - UART command frame parser driving register file, ALU and TX FIFO
// Ports:
//   clk, rst                    system clock, asynchronous active-high reset
//   rx_*                        received byte stream and its error flags
//   rf_*                        register-file write/read strobes, address, data
//   alu_*                       ALU start, function, clock enable, result
//   tx_fifo_*                   response byte push interface
//   cmd_error                   one-cycle pulse whenever a byte or frame is dropped
module uart_rx_cmd_ctrl
    import uart_sys_pkg::*;
#(
    parameter int D_WIDTH     = 8,
    parameter int ADDR_WIDTH  = 4,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rx_data_valid,
    input  logic [D_WIDTH-1:0]     rx_p_data,
    input  logic                   rx_parity_error,
    input  logic                   rx_framing_error,
    output logic                   rf_wr_en,
    output logic                   rf_rd_en,
    output logic [ADDR_WIDTH-1:0]  rf_addr,
    output logic [D_WIDTH-1:0]     rf_wr_data,
    input  logic [D_WIDTH-1:0]     rf_rd_data,
    input  logic                   rf_rd_valid,
    output logic                   alu_en,
    output logic [3:0]             alu_fun,
    output logic                   alu_clk_en,
    input  logic [2*D_WIDTH-1:0]   alu_out,
    input  logic                   alu_out_valid,
    output logic                   tx_fifo_wr_en,
    output logic [D_WIDTH-1:0]     tx_fifo_wr_data,
    input  logic                   tx_fifo_full,
    output logic                   cmd_error
);

    cmd_state_t           state;
    logic [2*D_WIDTH-1:0] resp_q;

    logic good_byte;
    logic bad_byte;
    logic collecting;
    logic push_ok;
    logic progress;
    logic to_hit;
    logic abort;

    assign good_byte  = rx_data_valid && !rx_parity_error && !rx_framing_error;
    assign bad_byte   = rx_data_valid && (rx_parity_error || rx_framing_error);
    assign collecting = is_collect(state);
    assign push_ok    = (state inside {SEND_RD, SEND_LO, SEND_HI}) && !tx_fifo_full;

    // Every event that moves the FSM out of its current state.
    assign progress = (collecting && good_byte)
                   || (state == RD_WAIT  && rf_rd_valid)
                   || (state == ALU_WAIT && alu_out_valid)
                   || push_ok;

    // A timeout loses to any real progress and to a byte arriving in the same
    // cycle (that byte restarts the idle interval).
    assign abort = (collecting && bad_byte)
                || (to_hit && !progress && !rx_data_valid);

    frame_timeout_counter #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .clk   (clk),
        .rst   (rst),
        .clear (rx_data_valid || progress || to_hit),
        .enable(state != IDLE),
        .tc    (to_hit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            resp_q          <= '0;
            rf_wr_en        <= 1'b0;
            rf_rd_en        <= 1'b0;
            rf_addr         <= '0;
            rf_wr_data      <= '0;
            alu_en          <= 1'b0;
            alu_fun         <= '0;
            alu_clk_en      <= 1'b0;
            tx_fifo_wr_en   <= 1'b0;
            tx_fifo_wr_data <= '0;
            cmd_error       <= 1'b0;
        end else begin
            rf_wr_en      <= 1'b0;
            rf_rd_en      <= 1'b0;
            alu_en        <= 1'b0;
            tx_fifo_wr_en <= 1'b0;
            cmd_error     <= 1'b0;

            if (abort) begin
                state      <= IDLE;
                cmd_error  <= 1'b1;
                alu_clk_en <= 1'b0;
            end else begin
                // Bytes arriving while a response is outstanding are dropped.
                if (rx_data_valid && state != IDLE && !collecting) begin
                    cmd_error <= 1'b1;
                end

                case (state)
                    IDLE: begin
                        if (bad_byte) begin
                            cmd_error <= 1'b1;
                        end else if (good_byte) begin
                            case (rx_p_data[7:0])
                                CMD_WR:      state <= WR_ADDR;
                                CMD_RD:      state <= RD_ADDR;
                                CMD_ALU_OP: begin
                                    state      <= OPA;
                                    alu_clk_en <= 1'b1;
                                end
                                CMD_ALU_NOP: begin
                                    state      <= ALU_FUN;
                                    alu_clk_en <= 1'b1;
                                end
                                default:     cmd_error <= 1'b1;
                            endcase
                        end
                    end
                    WR_ADDR: if (good_byte) begin
                        rf_addr <= rx_p_data[ADDR_WIDTH-1:0];
                        state   <= WR_DATA;
                    end
                    WR_DATA: if (good_byte) begin
                        rf_wr_en   <= 1'b1;
                        rf_wr_data <= rx_p_data;
                        state      <= IDLE;
                    end
                    RD_ADDR: if (good_byte) begin
                        rf_rd_en <= 1'b1;
                        rf_addr  <= rx_p_data[ADDR_WIDTH-1:0];
                        state    <= RD_WAIT;
                    end
                    RD_WAIT: if (rf_rd_valid) begin
                        resp_q <= {{D_WIDTH{1'b0}}, rf_rd_data};
                        state  <= SEND_RD;
                    end
                    OPA: if (good_byte) begin
                        rf_wr_en   <= 1'b1;
                        rf_addr    <= ADDR_WIDTH'(OPA_ADDR);
                        rf_wr_data <= rx_p_data;
                        state      <= OPB;
                    end
                    OPB: if (good_byte) begin
                        rf_wr_en   <= 1'b1;
                        rf_addr    <= ADDR_WIDTH'(OPB_ADDR);
                        rf_wr_data <= rx_p_data;
                        state      <= ALU_FUN;
                    end
                    ALU_FUN: if (good_byte) begin
                        alu_en  <= 1'b1;
                        alu_fun <= rx_p_data[3:0];
                        state   <= ALU_WAIT;
                    end
                    ALU_WAIT: if (alu_out_valid) begin
                        resp_q <= alu_out;
                        state  <= SEND_LO;
                    end
                    SEND_RD: if (!tx_fifo_full) begin
                        tx_fifo_wr_en   <= 1'b1;
                        tx_fifo_wr_data <= resp_q[D_WIDTH-1:0];
                        state           <= IDLE;
                    end
                    SEND_LO: begin
                        // Clock enable covers the cycle after the result arrives.
                        alu_clk_en <= 1'b0;
                        if (!tx_fifo_full) begin
                            tx_fifo_wr_en   <= 1'b1;
                            tx_fifo_wr_data <= resp_q[D_WIDTH-1:0];
                            state           <= SEND_HI;
                        end
                    end
                    SEND_HI: if (!tx_fifo_full) begin
                        tx_fifo_wr_en   <= 1'b1;
                        tx_fifo_wr_data <= resp_q[2*D_WIDTH-1:D_WIDTH];
                        state           <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_cmd_ctrl.sv
// tb/tb_uart_rx_cmd_ctrl.sv - self-checking bench for uart_rx_cmd_ctrl
module tb_uart_rx_cmd_ctrl;

    localparam int T = 40;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_data_valid;
    logic [7:0]  rx_p_data;
    logic        rx_parity_error;
    logic        rx_framing_error;
    logic        rf_wr_en;
    logic        rf_rd_en;
    logic [3:0]  rf_addr;
    logic [7:0]  rf_wr_data;
    logic [7:0]  rf_rd_data;
    logic        rf_rd_valid;
    logic        alu_en;
    logic [3:0]  alu_fun;
    logic        alu_clk_en;
    logic [15:0] alu_out;
    logic        alu_out_valid;
    logic        tx_fifo_wr_en;
    logic [7:0]  tx_fifo_wr_data;
    logic        tx_fifo_full;
    logic        cmd_error;

    uart_rx_cmd_ctrl #(
        .D_WIDTH(8), .ADDR_WIDTH(4), .TIMEOUT_CYC(T)
    ) dut (
        .clk(clk), .rst(rst),
        .rx_data_valid(rx_data_valid), .rx_p_data(rx_p_data),
        .rx_parity_error(rx_parity_error), .rx_framing_error(rx_framing_error),
        .rf_wr_en(rf_wr_en), .rf_rd_en(rf_rd_en), .rf_addr(rf_addr),
        .rf_wr_data(rf_wr_data), .rf_rd_data(rf_rd_data), .rf_rd_valid(rf_rd_valid),
        .alu_en(alu_en), .alu_fun(alu_fun), .alu_clk_en(alu_clk_en),
        .alu_out(alu_out), .alu_out_valid(alu_out_valid),
        .tx_fifo_wr_en(tx_fifo_wr_en), .tx_fifo_wr_data(tx_fifo_wr_data),
        .tx_fifo_full(tx_fifo_full), .cmd_error(cmd_error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed { logic [3:0] a; logic [7:0] d; } wr_t;

    wr_t        exp_wr_q[$];
    logic [3:0] exp_rd_q[$];
    logic [3:0] exp_alu_q[$];
    logic [7:0] exp_tx_q[$];
    int         exp_err = 0;
    int         wr_seen = 0, rd_seen = 0, tx_seen = 0;

    logic [7:0]  rd_value  = 8'h00;
    logic [15:0] alu_value = 16'h0000;
    logic        rd_resp_en = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        checks++;
        errors++;
        $display("FAIL %s: unexpected strobe, value %0h", name, act);
    endtask

    function automatic int pending();
        return exp_wr_q.size() + exp_rd_q.size() + exp_alu_q.size()
             + exp_tx_q.size() + exp_err;
    endfunction

    // Scoreboard side: pop an expectation whenever the DUT strobes something.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (rf_wr_en) begin
                    wr_seen++;
                    if (exp_wr_q.size() == 0) unexpected("rf_wr_en", 32'({rf_addr, rf_wr_data}));
                    else begin
                        e = exp_wr_q.pop_front();
                        chk("wr_addr", 32'(rf_addr), 32'(e.a));
                        chk("wr_data", 32'(rf_wr_data), 32'(e.d));
                    end
                end
                if (rf_rd_en) begin
                    rd_seen++;
                    if (exp_rd_q.size() == 0) unexpected("rf_rd_en", 32'(rf_addr));
                    else chk("rd_addr", 32'(rf_addr), 32'(exp_rd_q.pop_front()));
                end
                if (alu_en) begin
                    chk("alu_clk_en_at_start", 32'(alu_clk_en), 32'd1);
                    if (exp_alu_q.size() == 0) unexpected("alu_en", 32'(alu_fun));
                    else chk("alu_fun", 32'(alu_fun), 32'(exp_alu_q.pop_front()));
                end
                if (tx_fifo_wr_en) begin
                    tx_seen++;
                    if (exp_tx_q.size() == 0) unexpected("tx_fifo_wr_en", 32'(tx_fifo_wr_data));
                    else chk("tx_data", 32'(tx_fifo_wr_data), 32'(exp_tx_q.pop_front()));
                end
                if (cmd_error) begin
                    if (exp_err == 0) unexpected("cmd_error", 32'd1);
                    else exp_err--;
                end
            end
        end
    end

    // Register file read port: data two cycles after the strobe.
    initial begin
        rf_rd_valid = 1'b0;
        rf_rd_data  = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst && rf_rd_en && rd_resp_en) begin
                repeat (2) @(negedge clk);
                rf_rd_data  = rd_value;
                rf_rd_valid = 1'b1;
                @(negedge clk);
                rf_rd_valid = 1'b0;
            end
        end
    end

    // ALU: result two cycles after the start pulse.
    initial begin
        alu_out_valid = 1'b0;
        alu_out       = 16'h0000;
        forever begin
            @(negedge clk);
            if (!rst && alu_en) begin
                repeat (2) @(negedge clk);
                alu_out       = alu_value;
                alu_out_valid = 1'b1;
                chk("alu_clk_en_at_valid", 32'(alu_clk_en), 32'd1);
                @(negedge clk);
                alu_out_valid = 1'b0;
            end
        end
    end

    // Call at a negedge; returns at a negedge.
    task automatic send_byte(input logic [7:0] b, input logic perr, input logic ferr, input int gap);
        rx_data_valid    = 1'b1;
        rx_p_data        = b;
        rx_parity_error  = perr;
        rx_framing_error = ferr;
        @(negedge clk);
        rx_data_valid    = 1'b0;
        rx_parity_error  = 1'b0;
        rx_framing_error = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (pending() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        chk({name, "_pending"}, 32'(pending()), 32'd0);
        chk({name, "_alu_clk_en_idle"}, 32'(alu_clk_en), 32'd0);
    endtask

    typedef struct {
        string              name;
        int                 nb;
        logic [0:3][7:0]    b;
        logic [0:3]         bad;
        logic [7:0]         rd_val;
        logic [15:0]        alu_val;
        int                 n_wr;
        logic [0:1][3:0]    wa;
        logic [0:1][7:0]    wd;
        int                 n_rd;
        logic [3:0]         ra;
        int                 n_alu;
        logic [3:0]         fun;
        int                 n_tx;
        logic [0:1][7:0]    tx;
        int                 n_err;
    } vec_t;

    function automatic vec_t mk(
        string name, int nb, logic [0:3][7:0] b, logic [0:3] bad,
        logic [7:0] rd_val, logic [15:0] alu_val,
        int n_wr, logic [0:1][3:0] wa, logic [0:1][7:0] wd,
        int n_rd, logic [3:0] ra, int n_alu, logic [3:0] fun,
        int n_tx, logic [0:1][7:0] tx, int n_err);
        vec_t v;
        v.name = name; v.nb = nb; v.b = b; v.bad = bad;
        v.rd_val = rd_val; v.alu_val = alu_val;
        v.n_wr = n_wr; v.wa = wa; v.wd = wd;
        v.n_rd = n_rd; v.ra = ra; v.n_alu = n_alu; v.fun = fun;
        v.n_tx = n_tx; v.tx = tx; v.n_err = n_err;
        return v;
    endfunction

    localparam int NV = 11;
    vec_t vecs[NV];

    initial begin
        vec_t v;
        int   t0;
        int   n;

        //           name            nb bytes         bad      rd     alu       nwr wa     wd         nrd ra  nalu fun ntx tx         nerr
        vecs[0]  = mk("wr_basic",     3, 32'hAA053C00, 4'b0000, 8'h00, 16'h0000, 1, 8'h50, 16'h3C00, 0, 4'h0, 0, 4'h0, 0, 16'h0000, 0);
        vecs[1]  = mk("rd_basic",     2, 32'hBB050000, 4'b0000, 8'h3C, 16'h0000, 0, 8'h00, 16'h0000, 1, 4'h5, 0, 4'h0, 1, 16'h3C00, 0);
        vecs[2]  = mk("alu_op",       4, 32'hCC070300, 4'b0000, 8'h00, 16'h000A, 2, 8'h01, 16'h0703, 0, 4'h0, 1, 4'h0, 2, 16'h0A00, 0);
        vecs[3]  = mk("wr_parity",    3, 32'hAA053C00, 4'b0010, 8'h00, 16'h0000, 0, 8'h00, 16'h0000, 0, 4'h0, 0, 4'h0, 0, 16'h0000, 1);
        vecs[4]  = mk("wr_after_err", 3, 32'hAA021100, 4'b0000, 8'h00, 16'h0000, 1, 8'h20, 16'h1100, 0, 4'h0, 0, 4'h0, 0, 16'h0000, 0);
        vecs[5]  = mk("bad_opcode",   1, 32'h55000000, 4'b0000, 8'h00, 16'h0000, 0, 8'h00, 16'h0000, 0, 4'h0, 0, 4'h0, 0, 16'h0000, 1);
        vecs[6]  = mk("alu_nop",      2, 32'hDD050000, 4'b0000, 8'h00, 16'h1234, 0, 8'h00, 16'h0000, 0, 4'h0, 1, 4'h5, 2, 16'h3412, 0);
        vecs[7]  = mk("alu_abort",    3, 32'hCC094400, 4'b0010, 8'h00, 16'h0000, 1, 8'h00, 16'h0900, 0, 4'h0, 0, 4'h0, 0, 16'h0000, 1);
        vecs[8]  = mk("opcode_par",   1, 32'hAA000000, 4'b1000, 8'h00, 16'h0000, 0, 8'h00, 16'h0000, 0, 4'h0, 0, 4'h0, 0, 16'h0000, 1);
        vecs[9]  = mk("wr_addr_trunc",3, 32'hAAF79900, 4'b0000, 8'h00, 16'h0000, 1, 8'h70, 16'h9900, 0, 4'h0, 0, 4'h0, 0, 16'h0000, 0);
        vecs[10] = mk("alu_op_funF",  4, 32'hCCFF010F, 4'b0000, 8'h00, 16'hFE01, 2, 8'h01, 16'hFF01, 0, 4'h0, 1, 4'hF, 2, 16'h01FE, 0);

        rst = 1'b1;
        rx_data_valid = 1'b0; rx_p_data = 8'h00;
        rx_parity_error = 1'b0; rx_framing_error = 1'b0;
        tx_fifo_full = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_rf_wr_en", 32'(rf_wr_en), 0);
        chk("rst_rf_rd_en", 32'(rf_rd_en), 0);
        chk("rst_rf_addr", 32'(rf_addr), 0);
        chk("rst_rf_wr_data", 32'(rf_wr_data), 0);
        chk("rst_alu_en", 32'(alu_en), 0);
        chk("rst_alu_fun", 32'(alu_fun), 0);
        chk("rst_alu_clk_en", 32'(alu_clk_en), 0);
        chk("rst_tx_wr_en", 32'(tx_fifo_wr_en), 0);
        chk("rst_tx_data", 32'(tx_fifo_wr_data), 0);
        chk("rst_cmd_error", 32'(cmd_error), 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            v = vecs[i];
            rd_value  = v.rd_val;
            alu_value = v.alu_val;
            for (int k = 0; k < v.n_wr;  k++) exp_wr_q.push_back({v.wa[k], v.wd[k]});
            for (int k = 0; k < v.n_rd;  k++) exp_rd_q.push_back(v.ra);
            for (int k = 0; k < v.n_alu; k++) exp_alu_q.push_back(v.fun);
            for (int k = 0; k < v.n_tx;  k++) exp_tx_q.push_back(v.tx[k]);
            exp_err += v.n_err;
            for (int k = 0; k < v.nb; k++) send_byte(v.b[k], v.bad[k], 1'b0, 2);
            wait_idle(v.name);
        end

        // Back-to-back frames with no idle cycle between bytes.
        exp_wr_q.push_back({4'h1, 8'h22});
        exp_wr_q.push_back({4'h3, 8'h44});
        send_byte(8'hAA, 0, 0, 0); send_byte(8'h01, 0, 0, 0); send_byte(8'h22, 0, 0, 0);
        send_byte(8'hAA, 0, 0, 0); send_byte(8'h03, 0, 0, 0); send_byte(8'h44, 0, 0, 0);
        wait_idle("back_to_back");

        // Read response held off by a full TX FIFO.
        tx_fifo_full = 1'b1;
        rd_value = 8'h5A;
        exp_rd_q.push_back(4'h3);
        exp_tx_q.push_back(8'h5A);
        n = tx_seen;
        send_byte(8'hBB, 0, 0, 2);
        send_byte(8'h03, 0, 0, 2);
        repeat (14) @(negedge clk);
        chk("full_no_push", 32'(tx_seen - n), 0);
        tx_fifo_full = 1'b0;
        wait_idle("full_release");
        chk("full_one_push", 32'(tx_seen - n), 1);

        // Opcode only, then silence: timeout from RD_ADDR.
        exp_err += 1;
        n = rd_seen;
        send_byte(8'hBB, 0, 0, 0);
        t0 = 0;
        while (!cmd_error && t0 < 4 * T) begin
            @(negedge clk);
            t0++;
        end
        chk("timeout_latency", 32'(t0), 32'(T));
        wait_idle("timeout_frame");
        chk("timeout_no_rd", 32'(rd_seen - n), 0);

        // Missing read data plus a stray byte during RD_WAIT.
        rd_resp_en = 1'b0;
        exp_rd_q.push_back(4'h4);
        exp_err += 2;
        send_byte(8'hBB, 0, 0, 2);
        send_byte(8'h04, 0, 0, 6);
        send_byte(8'h77, 0, 0, 2);
        wait_idle("rd_wait_timeout");
        rd_resp_en = 1'b1;

        // Reset in the middle of a write frame.
        send_byte(8'hAA, 0, 0, 2);
        send_byte(8'h05, 0, 0, 1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_rf_wr_en", 32'(rf_wr_en), 0);
        chk("midrst_alu_clk_en", 32'(alu_clk_en), 0);
        chk("midrst_cmd_error", 32'(cmd_error), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        exp_wr_q.push_back({4'h6, 8'h77});
        send_byte(8'hAA, 0, 0, 2); send_byte(8'h06, 0, 0, 2); send_byte(8'h77, 0, 0, 2);
        wait_idle("after_reset");

        // Framing error on an opcode.
        exp_err += 1;
        send_byte(8'hDD, 0, 1, 2);
        wait_idle("opcode_framing");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", checks);
        $fatal(1, "watchdog");
    end

endmodule
